branch_resolve: RTL
===================

# branch_resolve

Branch resolution stage directly downstream of the ALU comparer. Each cycle it accepts the comparer's `eql`/`slt` flags plus a decoded branch/set opcode, decides whether the instruction redirects the PC, and drives a held redirect handshake to fetch. While the redirect is pending, and for a fixed number of cycles after fetch accepts it, the stage kills younger instructions. For set-less-than ops it also returns the zero-extended `slt` bit as a writeback value, and it keeps wrapping branch/taken performance counters.

## Interface
Parameters:
- `WIDTH`, 32: PC and data width.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after redirect acceptance; legal range 1–15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream presents an op this cycle.
- `in_ready`  out  1  stage can accept an op.
- `br_op`  in  3  op code: 000 NONE, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JUMP, 110 SET, 111 reserved.
- `eql`  in  1  equal flag from the comparer.
- `slt`  in  1  less-than flag from the comparer; signed/unsigned selection is already applied.
- `target`  in  WIDTH  branch/jump target PC.
- `redirect_valid`  out  1  PC redirect pending.
- `redirect_pc`  out  WIDTH  redirect target.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush`  out  1  kill younger instructions.
- `set_valid`  out  1  writeback value valid, one-cycle pulse.
- `set_val`  out  WIDTH  writeback value: `{WIDTH-1 zeros, slt}`.
- `br_count`  out  16  accepted branch/jump ops; wraps modulo 2^16.
- `taken_count`  out  16  taken ops; wraps modulo 2^16.

## Operation
- States: IDLE, REDIRECT, FLUSH. `in_ready` = (state == IDLE).
- An op is accepted when `in_valid && in_ready`. Ops offered while `in_ready` is low are ignored; upstream holds them.
- Taken conditions:
  - BEQ: `eql`.
  - BNE: `!eql`.
  - BLT: `slt`.
  - BGE: `!slt`.
  - JUMP: always.
  - NONE, SET, reserved: never.
- Accepted and taken: latch `target` into `redirect_pc`, go to REDIRECT. `redirect_valid=1` and `flush=1` in REDIRECT.
- REDIRECT exits when `redirect_ready` is sampled high. Then go to FLUSH and load the flush counter with `FLUSH_CYCLES-1`.
- While `redirect_valid` is high, `redirect_pc` is stable.
- FLUSH: `flush=1`. Decrement the counter each cycle; at 0, return to IDLE.
- Accepted and not taken: stay in IDLE; no redirect, no flush.
- Accepted SET: `set_valid=1` next cycle with `set_val={0…,slt}`. Otherwise `set_valid=0` and `set_val` holds its last value.
- Counters on acceptance:
  - `br_count` +1 for BEQ, BNE, BLT, BGE, JUMP.
  - `taken_count` +1 when taken.
- Reserved op: consumed like NONE; no counter change.
- Reset value of all outputs is 0, except `in_ready=1` (IDLE). Async reset mid-REDIRECT/FLUSH drops `redirect_valid` and `flush` immediately and returns to IDLE.

## Timing
- Op accepted at edge N → `redirect_valid`, `flush`, `set_valid` and counters reflect it after edge N. `in_ready` is low from after N.
- Redirect accepted at edge M → `redirect_valid` low after M. `flush` stays high through edge M+FLUSH_CYCLES; IDLE and `in_ready` high after that edge.
- Minimum taken-branch occupancy: 1 + FLUSH_CYCLES + 1 cycles from acceptance to next acceptance (with `redirect_ready` already high).
- `redirect_ready` high while not in REDIRECT: ignored.
- Outputs are registered; no combinational input-to-output path except `in_ready` from state.

## Structure
- `cpu_pkg`: `br_op_t` enum (the 3-bit encodings above) and `br_state_t` enum (IDLE/REDIRECT/FLUSH).
- Sub-module `br_cond`: combinational taken decode from `br_op`, `eql`, `slt`; reusable by a future early-branch path.
- Flush counter: 4-bit, inside `branch_resolve`.

## Test plan
- BEQ, `eql=1`, `target=0x0000_0040`, `redirect_ready=1` → `redirect_valid` 1 cycle with `redirect_pc=0x40`, then `flush` 2 more cycles; `taken_count=1`, `br_count=1`.
- BNE, `eql=1` → no redirect, no flush, `in_ready` stays 1; `br_count=1`, `taken_count=0`.
- BLT, `slt=1`, `redirect_ready` held low 3 cycles → `redirect_valid` and `flush` high 4 cycles with `redirect_pc` stable; `in_valid` offers during that time are ignored.
- SET, `slt=1` then SET, `slt=0` back-to-back → `set_valid` pulses on consecutive cycles with `set_val=1`, then `0`; counters unchanged.
- `rst_n` low during FLUSH → all outputs 0 and `in_ready=1` immediately; the next BGE with `slt=0` is accepted after release.
- 65536 JUMPs → `br_count` and `taken_count` wrap to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the branch resolution stage: op encodings, FSM states and
// the helper that classifies which ops count as branches.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_BLT  = 3'b011,
    OP_BGE  = 3'b100,
    OP_JUMP = 3'b101,
    OP_SET  = 3'b110,
    OP_RSVD = 3'b111
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_t;

  localparam int CNT_W = 16;

  function automatic logic is_branch(br_op_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_JUMP);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Upstream op, fetch redirect, writeback and counter signals of the branch
// resolution stage.
interface branch_resolve_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  br_op_t            br_op;
  logic              eql;
  logic              slt;
  logic [WIDTH-1:0]  target;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;
  logic              redirect_ready;
  logic              flush;
  logic              set_valid;
  logic [WIDTH-1:0]  set_val;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output in_valid, br_op, eql, slt, target, redirect_ready,
    input  in_ready, redirect_valid, redirect_pc, flush, set_valid, set_val,
           br_count, taken_count
  );

  modport slave (
    input  in_valid, br_op, eql, slt, target, redirect_ready,
    output in_ready, redirect_valid, redirect_pc, flush, set_valid, set_val,
           br_count, taken_count
  );
endinterface

// File: rtl/br_cond.sv
// Combinational taken decode from the comparer flags; kept standalone so an
// early-branch path can reuse it.
module br_cond
  import cpu_pkg::*;
(
  input  br_op_t op_i,
  input  logic   eql_i,
  input  logic   slt_i,
  output logic   taken_o,
  output logic   is_branch_o
);
  always_comb begin
    taken_o = 1'b0;
    unique case (op_i)
      OP_BEQ:  taken_o = eql_i;
      OP_BNE:  taken_o = !eql_i;
      OP_BLT:  taken_o = slt_i;
      OP_BGE:  taken_o = !slt_i;
      OP_JUMP: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

  assign is_branch_o = is_branch(op_i);
endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: decides redirects, holds the fetch handshake, kills
// younger instructions for a fixed window, returns SET results, counts branches.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
)(
  input logic             clk,
  input logic             rst_n,
  branch_resolve_if.slave bus
);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  br_state_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] redirect_pc_q;
  logic             set_valid_q;
  logic [WIDTH-1:0] set_val_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] taken_count_q;

  logic accept;
  logic taken;
  logic branch_op;

  br_cond u_cond (
    .op_i        (bus.br_op),
    .eql_i       (bus.eql),
    .slt_i       (bus.slt),
    .taken_o     (taken),
    .is_branch_o (branch_op)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && taken) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      redirect_pc_q <= '0;
      set_valid_q   <= 1'b0;
      set_val_q     <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_valid_q <= accept && (bus.br_op == OP_SET);
      // The target is only captured on a new redirect, so it stays stable while pending.
      if (accept && taken)                redirect_pc_q <= bus.target;
      if (accept && bus.br_op == OP_SET)  set_val_q     <= {{(WIDTH-1){1'b0}}, bus.slt};
      if (accept && branch_op)            br_count_q    <= br_count_q + 1'b1;
      if (accept && taken)                taken_count_q <= taken_count_q + 1'b1;
    end
  end

  assign bus.in_ready       = (state_q == ST_IDLE);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.flush          = (state_q != ST_IDLE);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.set_valid      = set_valid_q;
  assign bus.set_val        = set_val_q;
  assign bus.br_count       = br_count_q;
  assign bus.taken_count    = taken_count_q;
endmodule
